vga_pattern_gen: RTL

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

---
 rtl/vga_pattern_gen.sv | 125 ++++++++++++
 1 files changed

// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator: pixel divider, h/v counters,
// registered sync/colour outputs and a frame counter on the LEDs.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   reset  in   1  asynchronous active-low reset
//   sw     in   8  sw[1:0] pattern mode (latched at frame end),
//                  sw[7:2] colour seed (live)
//   hsync  out  1  horizontal sync, active level SYNC_POL
//   vsync  out  1  vertical sync, active level SYNC_POL
//   rgb    out  8  pixel colour, 8'h00 outside the visible area
//   led    out  8  frame counter
module vga_pattern_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit SYNC_POL  = 1'b0,
    parameter int BAR_SHIFT = 6,
    parameter int CHK_SHIFT = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sw,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] rgb,
    output logic [7:0] led
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [31:0] H_SS = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] H_SE = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] V_SS = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] V_SE = 32'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [31:0] H_VIS = 32'(H_ACTIVE);
    localparam logic [31:0] V_VIS = 32'(V_ACTIVE);

    logic [DW-1:0] div;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic [7:0]    frame_cnt;
    logic [1:0]    mode_q;

    logic          tick;
    logic          h_last;
    logic          v_last;
    logic [31:0]   hc;
    logic [31:0]   vc;
    logic          hs_d;
    logic          vs_d;
    logic          video_on;
    logic [2:0]    idx;
    logic          chk;
    logic [7:0]    pat;
    logic [7:0]    rgb_d;

    assign tick   = (div == DW'(CLK_DIV - 1));
    assign h_last = (hcount == HW'(H_TOTAL - 1));
    assign v_last = (vcount == VW'(V_TOTAL - 1));
    assign led    = frame_cnt;

    // Decode of the current counters; registered on the next tick,
    // so outputs trail the counters by one pixel.
    always_comb begin
        hc       = 32'(hcount);
        vc       = 32'(vcount);
        hs_d     = (hc >= H_SS && hc < H_SE) ? SYNC_POL : ~SYNC_POL;
        vs_d     = (vc >= V_SS && vc < V_SE) ? SYNC_POL : ~SYNC_POL;
        video_on = (hc < H_VIS) && (vc < V_VIS);
        idx      = 3'(hcount >> BAR_SHIFT);
        chk      = 1'(hcount >> CHK_SHIFT) ^ 1'(vcount >> CHK_SHIFT);
        pat      = 8'h00;
        case (mode_q)
            2'd0:    pat = {sw[7:2], sw[7:6]};
            2'd1:    pat = {idx, idx, idx[2:1]};
            2'd2:    pat = chk ? 8'hFF : 8'h00;
            default: pat = 8'(hcount) + frame_cnt;
        endcase
        rgb_d = video_on ? pat : 8'h00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div       <= '0;
            hcount    <= '0;
            vcount    <= '0;
            frame_cnt <= 8'h00;
            mode_q    <= 2'd0;
            hsync     <= ~SYNC_POL;
            vsync     <= ~SYNC_POL;
            rgb       <= 8'h00;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                hsync <= hs_d;
                vsync <= vs_d;
                rgb   <= rgb_d;
                if (h_last) begin
                    hcount <= '0;
                    if (v_last) begin
                        vcount    <= '0;
                        frame_cnt <= frame_cnt + 8'd1;
                        mode_q    <= sw[1:0];
                    end else begin
                        vcount <= vcount + 1'b1;
                    end
                end else begin
                    hcount <= hcount + 1'b1;
                end
            end
        end
    end

endmodule
